branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Parametrised branch/jump resolution unit for the execute stage of the RV32I core, generalising the original branch comparator. It evaluates all six conditional branches plus JAL/JALR, produces a registered PC redirect and link value, squashes a configurable number of younger instructions through a flush state machine that is stall-aware, flags misaligned targets, and keeps a saturating taken-branch counter for performance monitoring.

## Interface
- XLEN, 32, datapath width of PC, immediate and operands (≥ 32)
- FLUSH_DEPTH, 1, younger instructions squashed after a redirect (1..7)
- CNT_W, 16, width of the taken-branch counter
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset; one clock; reset is asynchronous and active-high
- i_valid  input  1  instruction in execute is valid
- i_stall  input  1  pipeline stall; no instruction accepted, flush count held
- pc  input  XLEN  PC of the instruction in execute
- imm  input  XLEN  sign-extended immediate
- rs1_val  input  XLEN  operand 1
- rs2_val  input  XLEN  operand 2
- branch_control  input  4  0 NOP, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL, 8 JALR, 9..15 NOP
- pc_update_control  output  1  one-cycle redirect strobe
- pc_update_val  output  XLEN  redirect target, valid with strobe, else 0
- ignore_curr_inst  output  1  instruction now in execute must be discarded
- link_valid  output  1  one-cycle strobe: link_val must be written to rd
- link_val  output  XLEN  pc+4 of the accepted JAL/JALR
- misalign_exc  output  1  one-cycle strobe: taken target not 4-byte aligned
- taken_count  output  CNT_W  number of redirects issued, saturating

## Operation
- Accept = i_valid & ~i_stall & state==IDLE. Non-accepted cycles make no decision.
- Compare: BEQ/BNE equality; BLT/BGE signed ($signed on both operands); BLTU/BGEU unsigned. JAL/JALR always taken.
- Target: branches and JAL = pc+imm; JALR = (rs1_val+imm) with bit 0 cleared. All sums modulo 2^XLEN (wrap, no overflow flag).
- Misaligned: taken and target[1:0]≠0 → misalign_exc, no redirect, no flush, no link, counter unchanged.
- Taken and aligned → redirect, flush, counter increment.
- JAL/JALR accepted → link_valid, link_val=pc+4 (independent of alignment only when aligned; suppressed on misalign).
- States: IDLE, FLUSH.
  - IDLE → FLUSH on accepted taken aligned branch/jump; flush counter loaded with FLUSH_DEPTH.
  - FLUSH: ignore_curr_inst=1; counter decrements on each ~i_stall cycle; on decrement from 1 → IDLE. i_valid ignored (squashed instructions never resolve).
- taken_count increments by 1 per redirect, holds at 2^CNT_W−1.

## Timing
- Latency 1: decision in accept cycle N; pc_update_control, pc_update_val, link_valid, link_val, misalign_exc registered and visible in cycle N+1 for exactly one cycle; pc_update_val returns to 0 afterwards.
- ignore_curr_inst high from cycle N+1 for FLUSH_DEPTH non-stalled cycles; stall cycles inside FLUSH extend it.
- taken_count updated in N+1.
- Stall in cycle N: nothing accepted, no strobes in N+1.
- Back-to-back: instruction following a redirect is always squashed; the first instruction accepted after FLUSH exits is resolved normally.
- Reset (asserted any cycle, including mid-FLUSH): state IDLE, flush counter 0, every output 0, taken_count 0; takes effect immediately, no strobe emitted on release.

## Test plan
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, FLUSH_DEPTH=1 → N+1: strobe=1, pc_update_val=0x120, ignore=1 one cycle, taken_count=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU same operands → not taken, no strobe, ignore=0.
- JALR rs1=0x203, imm=0, pc=0x40 → target 0x202 misaligned: misalign_exc=1, no redirect, link_valid=0; JALR rs1=0x201 → target 0x200, link_val=0x44, link_valid=1.
- FLUSH_DEPTH=3, taken BNE then i_stall high 2 cycles inside FLUSH → ignore high 5 cycles; valid taken branch during FLUSH produces no strobe.
- CNT_W=2: 5 taken branches → taken_count 1,2,3,3,3.
- i_rst asserted mid-FLUSH → ignore_curr_inst and all outputs 0 immediately; after release next BGEU 7≥7 resolves normally.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Operand/result bundle between the execute stage and the branch resolve unit.
// The pipeline side is the master; the resolver is the slave.
interface branch_resolve_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic            i_valid;
    logic            i_stall;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [3:0]      branch_control;

    logic             pc_update_control;
    logic [XLEN-1:0]  pc_update_val;
    logic             ignore_curr_inst;
    logic             link_valid;
    logic [XLEN-1:0]  link_val;
    logic             misalign_exc;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output i_valid, i_stall, pc, imm, rs1_val, rs2_val, branch_control,
        input  pc_update_control, pc_update_val, ignore_curr_inst, link_valid, link_val,
               misalign_exc, taken_count
    );

    modport slave (
        input  i_valid, i_stall, pc, imm, rs1_val, rs2_val, branch_control,
        output pc_update_control, pc_update_val, ignore_curr_inst, link_valid, link_val,
               misalign_exc, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: registered redirect and link, stall-aware
// squash of younger instructions, misaligned-target flag and taken counter.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CNT_W       = 16
) (
    input logic                  i_clk,
    input logic                  i_rst,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    localparam logic [3:0] BrBeq  = 4'd1;
    localparam logic [3:0] BrBne  = 4'd2;
    localparam logic [3:0] BrBlt  = 4'd3;
    localparam logic [3:0] BrBge  = 4'd4;
    localparam logic [3:0] BrBltu = 4'd5;
    localparam logic [3:0] BrBgeu = 4'd6;
    localparam logic [3:0] BrJal  = 4'd7;
    localparam logic [3:0] BrJalr = 4'd8;

    localparam logic [2:0]       FlushLoad = 3'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic             pc_upd_q, pc_upd_d;
    logic [XLEN-1:0]  pc_val_q, pc_val_d;
    logic             link_valid_q, link_valid_d;
    logic [XLEN-1:0]  link_val_q, link_val_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic            cond_taken;
    logic            is_jump;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            taken;
    logic            misaligned;
    logic            redirect;

    always_comb begin
        cond_taken = 1'b0;
        is_jump    = 1'b0;
        case (bus.branch_control)
            BrBeq:         cond_taken = (bus.rs1_val == bus.rs2_val);
            BrBne:         cond_taken = (bus.rs1_val != bus.rs2_val);
            BrBlt:         cond_taken = ($signed(bus.rs1_val) < $signed(bus.rs2_val));
            BrBge:         cond_taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
            BrBltu:        cond_taken = (bus.rs1_val < bus.rs2_val);
            BrBgeu:        cond_taken = (bus.rs1_val >= bus.rs2_val);
            BrJal, BrJalr: is_jump    = 1'b1;
            default:       ;
        endcase
        if (bus.branch_control == BrJalr) begin
            target = (bus.rs1_val + bus.imm) & ~XLEN'(1);
        end else begin
            target = bus.pc + bus.imm;
        end
    end

    assign accept     = bus.i_valid & ~bus.i_stall & (state_q == StIdle);
    assign taken      = cond_taken | is_jump;
    assign misaligned = taken & (|target[1:0]);
    assign redirect   = accept & taken & ~misaligned;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pc_upd_d     = redirect;
        pc_val_d     = redirect ? target : '0;
        link_valid_d = accept & is_jump & ~misaligned;
        link_val_d   = link_valid_d ? (bus.pc + XLEN'(4)) : '0;
        misalign_d   = accept & misaligned;
        taken_cnt_d  = taken_cnt_q;
        if (redirect && (taken_cnt_q != CntMax)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (redirect) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end
            end
            StFlush: begin
                // Stalled cycles do not advance the squash window.
                if (!bus.i_stall) begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                    if (flush_cnt_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            flush_cnt_q  <= '0;
            pc_upd_q     <= 1'b0;
            pc_val_q     <= '0;
            link_valid_q <= 1'b0;
            link_val_q   <= '0;
            misalign_q   <= 1'b0;
            taken_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            pc_upd_q     <= pc_upd_d;
            pc_val_q     <= pc_val_d;
            link_valid_q <= link_valid_d;
            link_val_q   <= link_val_d;
            misalign_q   <= misalign_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign bus.pc_update_control = pc_upd_q;
    assign bus.pc_update_val     = pc_val_q;
    assign bus.ignore_curr_inst  = (state_q == StFlush);
    assign bus.link_valid        = link_valid_q;
    assign bus.link_val          = link_val_q;
    assign bus.misalign_exc      = misalign_q;
    assign bus.taken_count       = taken_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: unit A (FLUSH_DEPTH=1, CNT_W=16) and unit B (FLUSH_DEPTH=3, CNT_W=2).
module tb_branch_resolve_unit;
    localparam logic [3:0] BEQ  = 4'd1;
    localparam logic [3:0] BNE  = 4'd2;
    localparam logic [3:0] BLT  = 4'd3;
    localparam logic [3:0] BGE  = 4'd4;
    localparam logic [3:0] BLTU = 4'd5;
    localparam logic [3:0] BGEU = 4'd6;
    localparam logic [3:0] JAL  = 4'd7;
    localparam logic [3:0] JALR = 4'd8;

    typedef struct packed {
        logic        v;
        logic        s;
        logic [3:0]  bc;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
    } stim_t;

    typedef struct packed {
        logic        upd;
        logic [31:0] uval;
        logic        ign;
        logic        lv;
        logic [31:0] lval;
        logic        mis;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(16)) bus_a ();
    branch_resolve_unit_if #(.XLEN(32), .CNT_W(2))  bus_b ();

    branch_resolve_unit #(.XLEN(32), .FLUSH_DEPTH(1), .CNT_W(16)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    branch_resolve_unit #(.XLEN(32), .FLUSH_DEPTH(3), .CNT_W(2)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    function automatic stim_t mk_stim(input logic v, input logic s, input logic [3:0] bc,
                                      input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] r1, input logic [31:0] r2);
        stim_t t;
        t.v = v; t.s = s; t.bc = bc; t.pc = pc; t.imm = imm; t.r1 = r1; t.r2 = r2;
        return t;
    endfunction

    function automatic obs_t mk_obs(input logic upd, input logic [31:0] uval, input logic ign,
                                    input logic lv, input logic [31:0] lval, input logic mis,
                                    input logic [15:0] cnt);
        obs_t o;
        o.upd = upd; o.uval = uval; o.ign = ign; o.lv = lv; o.lval = lval; o.mis = mis;
        o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t idle_exp(input logic ign, input logic [15:0] cnt);
        return mk_obs(1'b0, 32'h0, ign, 1'b0, 32'h0, 1'b0, cnt);
    endfunction

    function automatic obs_t sample(input bit sel);
        if (!sel) begin
            return mk_obs(bus_a.pc_update_control, bus_a.pc_update_val, bus_a.ignore_curr_inst,
                          bus_a.link_valid, bus_a.link_val, bus_a.misalign_exc,
                          bus_a.taken_count);
        end
        return mk_obs(bus_b.pc_update_control, bus_b.pc_update_val, bus_b.ignore_curr_inst,
                      bus_b.link_valid, bus_b.link_val, bus_b.misalign_exc,
                      16'(bus_b.taken_count));
    endfunction

    task automatic set_idle();
        bus_a.i_valid = 1'b0; bus_a.i_stall = 1'b0; bus_a.branch_control = 4'd0;
        bus_a.pc = 32'h0; bus_a.imm = 32'h0; bus_a.rs1_val = 32'h0; bus_a.rs2_val = 32'h0;
        bus_b.i_valid = 1'b0; bus_b.i_stall = 1'b0; bus_b.branch_control = 4'd0;
        bus_b.pc = 32'h0; bus_b.imm = 32'h0; bus_b.rs1_val = 32'h0; bus_b.rs2_val = 32'h0;
    endtask

    // Drive one instruction into the selected unit and queue what it must show next cycle.
    task automatic drive(input bit sel, input stim_t st, input obs_t exp);
        set_idle();
        if (!sel) begin
            bus_a.i_valid = st.v; bus_a.i_stall = st.s; bus_a.branch_control = st.bc;
            bus_a.pc = st.pc; bus_a.imm = st.imm; bus_a.rs1_val = st.r1; bus_a.rs2_val = st.r2;
        end else begin
            bus_b.i_valid = st.v; bus_b.i_stall = st.s; bus_b.branch_control = st.bc;
            bus_b.pc = st.pc; bus_b.imm = st.imm; bus_b.rs1_val = st.r1; bus_b.rs2_val = st.r2;
        end
        sb_q.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        set_idle();
        tick();
        tick();
        got = sample(1'b0);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_a: got=%h want=%h", got, obs_t'(0));
        end
        got = sample(1'b1);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_b: got=%h want=%h", got, obs_t'(0));
        end
        rst = 1'b0;
    endtask

    task automatic test_beq();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'h100, 32'h20, 32'd5, 32'd5));
        ex.push_back(mk_obs(1'b1, 32'h120, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1));
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'h300, 32'h8, 32'd1, 32'd1));
        ex.push_back(idle_exp(1'b0, 16'd1));
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'h200, 32'hFFFF_FFFC, 32'd0, 32'd0));
        ex.push_back(mk_obs(1'b1, 32'h1FC, 1'b1, 1'b0, 32'h0, 1'b0, 16'd2));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd2));
        foreach (st[i]) begin
            drive(1'b0, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b0);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL beq step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_compare();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mk_stim(1'b1, 1'b0, BLT, 32'h1000, 32'h10, 32'hFFFF_FFFF, 32'd1));
        ex.push_back(mk_obs(1'b1, 32'h1010, 1'b1, 1'b0, 32'h0, 1'b0, 16'd3));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd3));
        st.push_back(mk_stim(1'b1, 1'b0, BLTU, 32'h1000, 32'h10, 32'hFFFF_FFFF, 32'd1));
        ex.push_back(idle_exp(1'b0, 16'd3));
        st.push_back(mk_stim(1'b1, 1'b0, BGE, 32'h2000, 32'h8, 32'd1, 32'hFFFF_FFFF));
        ex.push_back(mk_obs(1'b1, 32'h2008, 1'b1, 1'b0, 32'h0, 1'b0, 16'd4));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd4));
        st.push_back(mk_stim(1'b1, 1'b0, BGEU, 32'h2000, 32'h8, 32'd1, 32'hFFFF_FFFF));
        ex.push_back(idle_exp(1'b0, 16'd4));
        st.push_back(mk_stim(1'b1, 1'b0, BNE, 32'h2000, 32'h8, 32'd3, 32'd3));
        ex.push_back(idle_exp(1'b0, 16'd4));
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9));
        ex.push_back(mk_obs(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 16'd5));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd5));
        st.push_back(mk_stim(1'b1, 1'b0, BLT, 32'h3000, 32'h8, 32'd1, 32'hFFFF_FFFF));
        ex.push_back(idle_exp(1'b0, 16'd5));
        foreach (st[i]) begin
            drive(1'b0, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b0);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL compare step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_jump();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mk_stim(1'b1, 1'b0, JALR, 32'h40, 32'h0, 32'h203, 32'h0));
        ex.push_back(mk_obs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 16'd5));
        st.push_back(mk_stim(1'b1, 1'b0, JALR, 32'h40, 32'h0, 32'h201, 32'h0));
        ex.push_back(mk_obs(1'b1, 32'h200, 1'b1, 1'b1, 32'h44, 1'b0, 16'd6));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd6));
        st.push_back(mk_stim(1'b1, 1'b0, JAL, 32'h80, 32'h100, 32'h0, 32'h0));
        ex.push_back(mk_obs(1'b1, 32'h180, 1'b1, 1'b1, 32'h84, 1'b0, 16'd7));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd7));
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'h100, 32'h6, 32'h0, 32'h0));
        ex.push_back(mk_obs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 16'd7));
        st.push_back(mk_stim(1'b1, 1'b1, JAL, 32'h80, 32'h100, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd7));
        st.push_back(mk_stim(1'b1, 1'b0, 4'd9, 32'h80, 32'h100, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd7));
        st.push_back(mk_stim(1'b1, 1'b0, JALR, 32'h1000, 32'hFFFF_FFF5, 32'h2000, 32'h0));
        ex.push_back(mk_obs(1'b1, 32'h1FF4, 1'b1, 1'b1, 32'h1004, 1'b0, 16'd8));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd8));
        foreach (st[i]) begin
            drive(1'b0, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b0);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jump step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_flush_stall();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(mk_stim(1'b1, 1'b0, BNE, 32'h300, 32'h40, 32'd1, 32'd2));
        ex.push_back(mk_obs(1'b1, 32'h340, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1));
        st.push_back(mk_stim(1'b1, 1'b1, BEQ, 32'h400, 32'h10, 32'd4, 32'd4));
        ex.push_back(idle_exp(1'b1, 16'd1));
        st.push_back(mk_stim(1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b1, 16'd1));
        st.push_back(mk_stim(1'b1, 1'b0, BEQ, 32'h400, 32'h10, 32'd4, 32'd4));
        ex.push_back(idle_exp(1'b1, 16'd1));
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b1, 16'd1));
        st.push_back(mk_stim(1'b1, 1'b0, JAL, 32'h400, 32'h10, 32'd0, 32'd0));
        ex.push_back(idle_exp(1'b0, 16'd1));
        foreach (st[i]) begin
            drive(1'b1, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b1);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL flush_stall step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        drive(1'b1, mk_stim(1'b1, 1'b0, BEQ, 32'h500, 32'h10, 32'd0, 32'd0),
              mk_obs(1'b1, 32'h510, 1'b1, 1'b0, 32'h0, 1'b0, 16'd2));
        tick();
        want = sb_q.pop_front();
        got  = sample(1'b1);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL rst_pre: got=%h want=%h", got, want);
        end
        // Assert reset between edges while unit B is squashing.
        rst = 1'b1;
        #1;
        got = sample(1'b1);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL rst_async_b: got=%h want=%h", got, obs_t'(0));
        end
        got = sample(1'b0);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL rst_async_a: got=%h want=%h", got, obs_t'(0));
        end
        tick();
        rst = 1'b0;
        st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
        ex.push_back(idle_exp(1'b0, 16'd0));
        st.push_back(mk_stim(1'b1, 1'b0, BGEU, 32'h600, 32'h20, 32'd7, 32'd7));
        ex.push_back(mk_obs(1'b1, 32'h620, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
            ex.push_back(idle_exp((k < 2) ? 1'b1 : 1'b0, 16'd1));
        end
        foreach (st[i]) begin
            drive(1'b1, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b1);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rst_post step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        logic [15:0] cnt;
        logic [31:0] bpc;
        rst = 1'b1;
        set_idle();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cnt = (k < 3) ? 16'(k + 1) : 16'd3;
            bpc = 32'h1000 + 32'(k * 16);
            st.push_back(mk_stim(1'b1, 1'b0, BEQ, bpc, 32'h40, 32'd2, 32'd2));
            ex.push_back(mk_obs(1'b1, bpc + 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, cnt));
            for (int j = 0; j < 3; j++) begin
                st.push_back(mk_stim(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0));
                ex.push_back(idle_exp((j < 2) ? 1'b1 : 1'b0, cnt));
            end
        end
        foreach (st[i]) begin
            drive(1'b1, st[i], ex[i]);
            tick();
            want = sb_q.pop_front();
            got  = sample(1'b1);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL saturate step %0d: got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        test_reset();
        test_beq();
        test_compare();
        test_jump();
        test_flush_stall();
        test_reset_mid_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
